// File: rtl/usb_host_trans_queue_bi.sv
`default_nettype none
// ============================================================================
// Module   : usb_host_trans_queue_bi
// Desc     : Host-control register interface that queues USB transaction
//            descriptors, issues them one at a time to the transaction engine
//            and collects completions into a result FIFO with sticky,
//            maskable interrupts. Abort-on-timeout: USB_HOST_TQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module usb_host_trans_queue_bi #(
    parameter int          QUEUE_DEPTH    = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000
) (
    input  logic       busClk,
    input  logic       rstSyncToBusClk,
    input  logic [3:0] address,
    input  logic [7:0] dataIn,
    output logic [7:0] dataOut,
    input  logic       writeEn,
    input  logic       strobe_i,
    input  logic       hostControlSelect,
    output logic       intOut,
    output logic       transReq,
    output logic [1:0] TxTransType,
    output logic [6:0] TxAddr,
    output logic [3:0] TxEndP,
    output logic       isoEn,
    output logic       preambleEn,
    input  logic       transDone,
    input  logic [7:0] RxPktStatus,
    input  logic [3:0] RxPID
);

    localparam int              c_AW      = $clog2(QUEUE_DEPTH);
    localparam int              c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(QUEUE_DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_REQ  = 1'b1;

    localparam logic [3:0] c_A_CTRL   = 4'd0;
    localparam logic [3:0] c_A_STYPE  = 4'd1;
    localparam logic [3:0] c_A_SADDR  = 4'd2;
    localparam logic [3:0] c_A_SENDP  = 4'd3;
    localparam logic [3:0] c_A_QSTAT  = 4'd4;
    localparam logic [3:0] c_A_RSTS   = 4'd5;
    localparam logic [3:0] c_A_RPID   = 4'd6;
    localparam logic [3:0] c_A_RSTAT  = 4'd7;
    localparam logic [3:0] c_A_ISTAT  = 4'd8;
    localparam logic [3:0] c_A_IMASK  = 4'd9;
    localparam logic [3:0] c_A_THRESH = 4'd10;

`ifdef USB_HOST_TQ_TIMEOUT_EN
    localparam logic [4:0] c_INT_BITS = 5'h1F;
`else
    localparam logic [4:0] c_INT_BITS = 5'h0F;
`endif

    logic [0:0]      r_state, w_stateNext;
    logic            r_transReq;
    logic            r_run;
    logic [1:0]      r_stageType;
    logic            r_stageIso, r_stagePre;
    logic [6:0]      r_stageAddr;
    logic [3:0]      r_stageEndP;
    logic [2:0]      r_tag;
    logic [4:0]      r_intStatus, r_intMask;
    logic [3:0]      r_resThresh;

    // Descriptor entry: {type[1:0], iso, pre, addr[6:0], endp[3:0], tag[2:0]}
    logic [17:0]     r_descMem [QUEUE_DEPTH];
    logic [c_AW-1:0] r_descRd, r_descWr;
    logic [c_CW-1:0] r_descCount;
    // Result entry: {status[7:0], pid[3:0], tag[2:0]}
    logic [14:0]     r_resMem [QUEUE_DEPTH];
    logic [c_AW-1:0] r_resRd, r_resWr;
    logic [c_CW-1:0] r_resCount;

    logic            w_wr, w_push, w_flush, w_timeout, w_complete, w_unused_ok;
    logic            w_descEmpty, w_descFull, w_resEmpty, w_resFull;
    logic            w_keepHead, w_pushOk, w_pushDrop;
    logic [c_CW-1:0] w_descBaseCnt, w_descCountNext;
    logic [c_AW-1:0] w_descBaseWr, w_descWrNext, w_descRdNext;
    logic            w_resPop, w_resPushOk, w_resDrop;
    logic [c_CW-1:0] w_resCountNext;
    logic [17:0]     w_descHead;
    logic [14:0]     w_resHead;
    logic [14:0]     w_resEntry;
    logic [4:0]      w_intSet, w_intClr;

    assign w_wr        = writeEn & strobe_i & hostControlSelect;
    assign w_push      = w_wr && (address == c_A_CTRL) && dataIn[0];
    assign w_flush     = w_wr && (address == c_A_CTRL) && dataIn[1];
    assign w_descEmpty = (r_descCount == '0);
    assign w_descFull  = (r_descCount == c_DEPTH);
    assign w_resEmpty  = (r_resCount == '0);
    assign w_resFull   = (r_resCount == c_DEPTH);
    assign w_descHead  = r_descMem[r_descRd];
    assign w_resHead   = r_resMem[r_resRd];

`ifdef USB_HOST_TQ_TIMEOUT_EN
    logic [15:0] r_tmoCount;

    // Restarts from zero on every entry to REQ
    always_ff @(posedge busClk) begin
        if (rstSyncToBusClk || (r_state != c_ST_REQ)) begin
            r_tmoCount <= '0;
        end else begin
            r_tmoCount <= r_tmoCount + 16'd1;
        end
    end

    assign w_timeout   = (r_state == c_ST_REQ) && !transDone &&
                         (r_tmoCount == (TIMEOUT_CYCLES - 16'd1));
    assign w_unused_ok = &{1'b0, dataIn[7]};
`else
    assign w_timeout   = 1'b0;
    assign w_unused_ok = &{1'b0, dataIn[7], TIMEOUT_CYCLES};
`endif

    assign w_complete = ((r_state == c_ST_REQ) && transDone) || w_timeout;
    assign w_resEntry = w_timeout ? {8'hFF, 4'h0, w_descHead[2:0]}
                                  : {RxPktStatus, RxPID, w_descHead[2:0]};

    // Flush is applied before push; a flushed in-flight head survives
    always_comb begin
        w_keepHead    = 1'b0;
        w_descRdNext  = r_descRd;
        w_descBaseCnt = r_descCount;
        w_descBaseWr  = r_descWr;
        if (w_complete) begin
            w_descRdNext  = r_descRd + c_PTR_ONE;
            w_descBaseCnt = r_descCount - c_CNT_ONE;
        end
        if (w_flush) begin
            w_keepHead    = (r_state == c_ST_REQ) && !w_complete;
            w_descBaseCnt = w_keepHead ? c_CNT_ONE : '0;
            w_descBaseWr  = w_keepHead ? (r_descRd + c_PTR_ONE) : w_descRdNext;
        end
        w_pushOk        = w_push && (w_descBaseCnt != c_DEPTH);
        w_pushDrop      = w_push && !w_pushOk;
        w_descCountNext = w_descBaseCnt;
        w_descWrNext    = w_descBaseWr;
        if (w_pushOk) begin
            w_descCountNext = w_descBaseCnt + c_CNT_ONE;
            w_descWrNext    = w_descBaseWr + c_PTR_ONE;
        end
    end

    always_comb begin
        w_resPop       = w_wr && (address == c_A_RPID) && !w_resEmpty;
        w_resPushOk    = w_complete && (!w_resFull || w_resPop);
        w_resDrop      = w_complete && !w_resPushOk;
        w_resCountNext = r_resCount;
        if (w_resPushOk && !w_resPop) begin
            w_resCountNext = r_resCount + c_CNT_ONE;
        end else if (!w_resPushOk && w_resPop) begin
            w_resCountNext = r_resCount - c_CNT_ONE;
        end
    end

    always_comb begin
        w_intSet[0] = w_complete;
        w_intSet[1] = !w_descEmpty && (w_descCountNext == '0);
        w_intSet[2] = w_pushDrop || w_resDrop;
        w_intSet[3] = (r_resThresh != 4'd0) && (w_resCountNext != r_resCount) &&
                      (4'(w_resCountNext) == r_resThresh);
        w_intSet[4] = w_timeout;
        w_intClr    = (w_wr && (address == c_A_ISTAT)) ? dataIn[4:0] : 5'd0;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_IDLE: if (r_run && !w_descEmpty && !w_flush) w_stateNext = c_ST_REQ;
            c_ST_REQ:  if (w_complete) w_stateNext = c_ST_IDLE;
            default:   w_stateNext = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge busClk) begin
        if (rstSyncToBusClk) begin
            r_state     <= c_ST_IDLE;
            r_transReq  <= 1'b0;
            r_run       <= 1'b0;
            r_stageType <= '0;
            r_stageIso  <= 1'b0;
            r_stagePre  <= 1'b0;
            r_stageAddr <= '0;
            r_stageEndP <= '0;
            r_tag       <= '0;
            r_intStatus <= '0;
            r_intMask   <= '0;
            r_resThresh <= '0;
            r_descRd    <= '0;
            r_descWr    <= '0;
            r_descCount <= '0;
            r_resRd     <= '0;
            r_resWr     <= '0;
            r_resCount  <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_transReq  <= (r_state == c_ST_REQ);
            r_descRd    <= w_descRdNext;
            r_descWr    <= w_descWrNext;
            r_descCount <= w_descCountNext;
            r_resCount  <= w_resCountNext;
            r_intStatus <= (r_intStatus & ~w_intClr) | w_intSet;
            if (w_pushOk)    r_tag   <= r_tag + 3'd1;
            if (w_resPushOk) r_resWr <= r_resWr + c_PTR_ONE;
            if (w_resPop)    r_resRd <= r_resRd + c_PTR_ONE;
            if (w_wr) begin
                case (address)
                    c_A_CTRL:   r_run <= dataIn[2];
                    c_A_STYPE:  {r_stagePre, r_stageIso, r_stageType} <= dataIn[3:0];
                    c_A_SADDR:  r_stageAddr <= dataIn[6:0];
                    c_A_SENDP:  r_stageEndP <= dataIn[3:0];
                    c_A_IMASK:  r_intMask   <= dataIn[4:0] & c_INT_BITS;
                    c_A_THRESH: r_resThresh <= dataIn[3:0];
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge busClk) begin
        if (w_pushOk) begin
            r_descMem[w_descBaseWr] <= {r_stageType, r_stageIso, r_stagePre,
                                        r_stageAddr, r_stageEndP, r_tag};
        end
        if (w_resPushOk) begin
            r_resMem[r_resWr] <= w_resEntry;
        end
    end

    always_comb begin
        dataOut = 8'h00;
        case (address)
            c_A_CTRL:   dataOut = {5'b0, r_run, 1'b0, (r_state == c_ST_REQ)};
            c_A_STYPE:  dataOut = {4'b0, r_stagePre, r_stageIso, r_stageType};
            c_A_SADDR:  dataOut = {1'b0, r_stageAddr};
            c_A_SENDP:  dataOut = {4'b0, r_stageEndP};
            c_A_QSTAT:  dataOut = {4'(r_descCount), 2'b0, w_descFull, w_descEmpty};
            c_A_RSTS:   dataOut = w_resEmpty ? 8'h00 : w_resHead[14:7];
            c_A_RPID:   dataOut = w_resEmpty ? 8'h00 : {1'b0, w_resHead[2:0], w_resHead[6:3]};
            c_A_RSTAT:  dataOut = {4'(r_resCount), 2'b0, w_resFull, w_resEmpty};
            c_A_ISTAT:  dataOut = {3'b0, r_intStatus};
            c_A_IMASK:  dataOut = {3'b0, r_intMask};
            c_A_THRESH: dataOut = {4'b0, r_resThresh};
            default:    dataOut = 8'h00;
        endcase
    end

    assign intOut      = |(r_intStatus & r_intMask);
    assign transReq    = r_transReq;
    assign TxTransType = w_descEmpty ? 2'b0 : w_descHead[17:16];
    assign isoEn       = w_descEmpty ? 1'b0 : w_descHead[15];
    assign preambleEn  = w_descEmpty ? 1'b0 : w_descHead[14];
    assign TxAddr      = w_descEmpty ? 7'b0 : w_descHead[13:7];
    assign TxEndP      = w_descEmpty ? 4'b0 : w_descHead[6:3];

endmodule
`default_nettype wire

// File: tb/tb_usb_host_trans_queue_bi.sv
`default_nettype none
// Bench for usb_host_trans_queue_bi: queue-based descriptor/result model plus
// an emulated transaction engine; directed scenarios then a randomized mix.
module tb_usb_host_trans_queue_bi;

    localparam int DEPTH = 4;
`ifdef USB_HOST_TQ_TIMEOUT_EN
    localparam logic [15:0] TMO       = 16'd20;
    localparam logic [4:0]  MASK_BITS = 5'h1F;
`else
    localparam logic [15:0] TMO       = 16'd60000;
    localparam logic [4:0]  MASK_BITS = 5'h0F;
`endif

    typedef struct packed {
        logic [1:0] ty; logic iso; logic pre; logic [6:0] addr; logic [3:0] endp; logic [2:0] tag;
    } desc_t;
    typedef struct packed {
        logic [7:0] st; logic [3:0] pid; logic [2:0] tag;
    } res_t;

    logic       busClk = 1'b0;
    logic       rstSyncToBusClk;
    logic [3:0] address;
    logic [7:0] dataIn, dataOut;
    logic       writeEn, strobe_i, hostControlSelect;
    logic       intOut, transReq, isoEn, preambleEn, transDone;
    logic [1:0] TxTransType;
    logic [6:0] TxAddr;
    logic [3:0] TxEndP, RxPID;
    logic [7:0] RxPktStatus;

    desc_t      mDesc[$];
    res_t       mRes[$];
    logic [4:0] mInt, mMask;
    logic [3:0] mThr;
    logic [2:0] mTag;
    logic       mRun;
    int         checks = 0;
    int         failures = 0;

    always #5 busClk = ~busClk;

    usb_host_trans_queue_bi #(.QUEUE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .busClk(busClk), .rstSyncToBusClk(rstSyncToBusClk), .address(address),
        .dataIn(dataIn), .dataOut(dataOut), .writeEn(writeEn), .strobe_i(strobe_i),
        .hostControlSelect(hostControlSelect), .intOut(intOut), .transReq(transReq),
        .TxTransType(TxTransType), .TxAddr(TxAddr), .TxEndP(TxEndP), .isoEn(isoEn),
        .preambleEn(preambleEn), .transDone(transDone), .RxPktStatus(RxPktStatus), .RxPID(RxPID)
    );

    function automatic logic [7:0] exp_qstat();
        return {4'(mDesc.size()), 2'b0, mDesc.size() == DEPTH, mDesc.size() == 0};
    endfunction

    function automatic logic [7:0] exp_rstat();
        return {4'(mRes.size()), 2'b0, mRes.size() == DEPTH, mRes.size() == 0};
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge busClk);
        address = a; dataIn = d; writeEn = 1'b1; strobe_i = 1'b1; hostControlSelect = 1'b1;
        @(posedge busClk); #1;
        writeEn = 1'b0; strobe_i = 1'b0; hostControlSelect = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge busClk);
        address = a; #1;
        d = dataOut;
    endtask

    task automatic do_reset();
        rstSyncToBusClk = 1'b1; transDone = 1'b0; RxPktStatus = '0; RxPID = '0;
        writeEn = 1'b0; strobe_i = 1'b0; hostControlSelect = 1'b0; address = '0; dataIn = '0;
        repeat (3) @(posedge busClk);
        #1 rstSyncToBusClk = 1'b0;
        mDesc.delete(); mRes.delete();
        mInt = '0; mMask = '0; mThr = '0; mTag = '0; mRun = 1'b0;
    endtask

    task automatic set_run(input logic r);
        mRun = r;
        bus_write(4'd0, {5'b0, r, 2'b00});
    endtask

    task automatic push_desc(input logic [1:0] ty, input logic iso, input logic pre,
                             input logic [6:0] addr, input logic [3:0] endp);
        desc_t e;
        bus_write(4'd1, {4'b0, pre, iso, ty});
        bus_write(4'd2, {1'b0, addr});
        bus_write(4'd3, {4'b0, endp});
        bus_write(4'd0, {5'b0, mRun, 2'b01});
        if (mDesc.size() == DEPTH) begin
            mInt[2] = 1'b1;
        end else begin
            e.ty = ty; e.iso = iso; e.pre = pre; e.addr = addr; e.endp = endp; e.tag = mTag;
            mDesc.push_back(e);
            mTag = mTag + 3'd1;
        end
    endtask

    task automatic pop_result();
        bus_write(4'd6, 8'h00);
        if (mRes.size() != 0) begin
            void'(mRes.pop_front());
            if (mThr != 0 && mRes.size() == int'(mThr)) mInt[3] = 1'b1;
        end
    endtask

    task automatic w1c(input logic [7:0] d);
        bus_write(4'd8, d);
        mInt = mInt & ~d[4:0];
    endtask

    task automatic wait_req(output bit seen);
        int n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge busClk);
            if (transReq === 1'b1) seen = 1'b1; else n++;
        end
    endtask

    // Engine emulation: waits for a request, checks head fields, pulses transDone
    task automatic serve(input logic [7:0] st, input logic [3:0] pid,
                         input bit doClr, input logic [7:0] clr);
        bit    seen;
        desc_t h;
        res_t  r;
        wait_req(seen);
        checks++;
        if (!seen || mDesc.size() == 0) begin
            failures++;
            $display("FAIL serve_wait transReq=%b queued=%0d required a request", transReq, mDesc.size());
            return;
        end
        h = mDesc[0];
        checks++;
        if ({TxTransType, isoEn, preambleEn, TxAddr, TxEndP} !== {h.ty, h.iso, h.pre, h.addr, h.endp}) begin
            failures++;
            $display("FAIL tx_fields got %h required %h", {TxTransType, isoEn, preambleEn, TxAddr, TxEndP},
                     {h.ty, h.iso, h.pre, h.addr, h.endp});
        end
        transDone = 1'b1; RxPktStatus = st; RxPID = pid;
        if (doClr) begin
            address = 4'd8; dataIn = clr; writeEn = 1'b1; strobe_i = 1'b1; hostControlSelect = 1'b1;
        end
        @(posedge busClk); #1;
        transDone = 1'b0; writeEn = 1'b0; strobe_i = 1'b0; hostControlSelect = 1'b0;
        if (doClr) mInt = mInt & ~clr[4:0];
        void'(mDesc.pop_front());
        mInt[0] = 1'b1;
        if (mDesc.size() == 0) mInt[1] = 1'b1;
        if (mRes.size() == DEPTH) begin
            mInt[2] = 1'b1;
        end else begin
            r.st = st; r.pid = pid; r.tag = h.tag;
            mRes.push_back(r);
            if (mThr != 0 && mRes.size() == int'(mThr)) mInt[3] = 1'b1;
        end
        @(posedge busClk); #1;
    endtask

    task automatic test_reset();
        logic [7:0] d, e;
        do_reset();
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), d);
            e = (a == 4 || a == 7) ? 8'h01 : 8'h00;
            checks++;
            if (d !== e) begin failures++; $display("FAIL reset_reg%0d got %h required %h", a, d, e); end
        end
        checks++;
        if ({intOut, transReq, TxTransType, TxAddr, TxEndP, isoEn, preambleEn} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h required 0", {intOut, transReq, TxTransType, TxAddr, TxEndP, isoEn, preambleEn});
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        do_reset();
        push_desc(2'd2, 1'b0, 1'b0, 7'h15, 4'd3);
        set_run(1'b1);
        @(negedge busClk);
        checks++; if (transReq !== 1'b0) begin failures++; $display("FAIL req_early0 got %b required 0", transReq); end
        @(negedge busClk);
        checks++; if (transReq !== 1'b0) begin failures++; $display("FAIL req_early1 got %b required 0", transReq); end
        @(negedge busClk);
        checks++; if (transReq !== 1'b1) begin failures++; $display("FAIL req_rise got %b required 1", transReq); end
        checks++;
        if (TxAddr !== 7'h15 || TxEndP !== 4'd3 || TxTransType !== 2'd2) begin
            failures++; $display("FAIL basic_tx got addr=%h endp=%h type=%h required 15/3/2", TxAddr, TxEndP, TxTransType);
        end
        serve(8'h00, 4'h2, 1'b0, 8'h00);
        checks++; if (transReq !== 1'b0) begin failures++; $display("FAIL req_fall got %b required 0", transReq); end
        bus_read(4'd5, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL basic_status got %h required 00", d); end
        bus_read(4'd6, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL basic_pid got %h required 02", d); end
        bus_read(4'd8, d);
        checks++; if (d !== 8'h03) begin failures++; $display("FAIL basic_int got %h required 03", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d, e;
        do_reset();
        for (int i = 0; i < 5; i++) push_desc(2'(i), 1'b0, 1'b1, 7'(i + 16), 4'(i));
        bus_read(4'd4, d);
        checks++; if (d !== 8'h42) begin failures++; $display("FAIL ovf_qstat got %h required 42", d); end
        bus_read(4'd8, d);
        checks++; if (d !== 8'h04) begin failures++; $display("FAIL ovf_error got %h required 04", d); end
        set_run(1'b1);
        for (int i = 0; i < 4; i++) serve(8'(i + 8'h10), 4'(i + 5), 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            bus_read(4'd6, d);
            e = {1'b0, 3'(i), 4'(i + 5)};
            checks++; if (d !== e) begin failures++; $display("FAIL ovf_order%0d got %h required %h", i, d, e); end
            pop_result();
        end
    endtask

    task automatic test_result_full();
        logic [7:0] d, e;
        do_reset();
        for (int i = 0; i < 4; i++) push_desc(2'd1, 1'b0, 1'b0, 7'(i), 4'd1);
        set_run(1'b1);
        for (int i = 0; i < 4; i++) serve(8'(i + 1), 4'h3, 1'b0, 8'h00);
        push_desc(2'd0, 1'b1, 1'b0, 7'h7F, 4'hF);
        serve(8'hAA, 4'h9, 1'b0, 8'h00);
        bus_read(4'd7, d);
        checks++; if (d !== 8'h42) begin failures++; $display("FAIL full_rstat got %h required 42", d); end
        bus_read(4'd4, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL full_qstat got %h required 01", d); end
        bus_read(4'd8, d);
        checks++; if (d[2] !== 1'b1) begin failures++; $display("FAIL full_error got %h required bit2 set", d); end
        for (int i = 0; i < 4; i++) begin
            bus_read(4'd5, d);
            e = 8'(i + 1);
            checks++; if (d !== e) begin failures++; $display("FAIL full_status%0d got %h required %h", i, d, e); end
            pop_result();
        end
        bus_read(4'd7, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL full_drain got %h required 01", d); end
    endtask

    task automatic test_flush();
        logic [7:0] d;
        bit seen;
        int hits = 0;
        do_reset();
        for (int i = 0; i < 3; i++) push_desc(2'd3, 1'b0, 1'b0, 7'(i + 40), 4'd2);
        set_run(1'b1);
        wait_req(seen);
        checks++; if (!seen) begin failures++; $display("FAIL flush_req got 0 required 1"); end
        bus_write(4'd0, {5'b0, mRun, 2'b10});
        while (mDesc.size() > 1) void'(mDesc.pop_back());
        bus_read(4'd4, d);
        checks++; if (d !== 8'h10) begin failures++; $display("FAIL flush_qstat got %h required 10", d); end
        bus_read(4'd8, d);
        checks++; if (d[1] !== 1'b0) begin failures++; $display("FAIL flush_qe_early got %h required bit1 clear", d); end
        serve(8'h05, 4'h1, 1'b0, 8'h00);
        bus_read(4'd8, d);
        checks++; if (d !== {3'b0, mInt} || d[1] !== 1'b1) begin failures++; $display("FAIL flush_int got %h required %h", d, {3'b0, mInt}); end
        bus_read(4'd4, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL flush_empty got %h required 01", d); end
        repeat (10) begin @(negedge busClk); if (transReq !== 1'b0) hits++; end
        checks++; if (hits != 0) begin failures++; $display("FAIL flush_noreq got %0d required 0", hits); end
    endtask

    task automatic test_threshold();
        logic [7:0] d;
        do_reset();
        bus_write(4'd10, 8'd2); mThr = 4'd2;
        bus_write(4'd9, 8'h08); mMask = 5'h08;
        for (int i = 0; i < 3; i++) push_desc(2'd0, 1'b0, 1'b0, 7'(i), 4'd0);
        set_run(1'b1);
        serve(8'h11, 4'h1, 1'b0, 8'h00);
        checks++; if (intOut !== 1'b0) begin failures++; $display("FAIL thr_first got %b required 0", intOut); end
        serve(8'h22, 4'h2, 1'b0, 8'h00);
        checks++; if (intOut !== 1'b1) begin failures++; $display("FAIL thr_second got %b required 1", intOut); end
        pop_result();
        w1c(8'h08);
        checks++; if (intOut !== 1'b0) begin failures++; $display("FAIL thr_clear got %b required 0", intOut); end
        serve(8'h33, 4'h3, 1'b1, 8'h08);
        bus_read(4'd8, d);
        checks++; if (d !== {3'b0, mInt} || d[3] !== 1'b1) begin failures++; $display("FAIL thr_setwins got %h required %h", d, {3'b0, mInt}); end
        checks++; if (intOut !== 1'b1) begin failures++; $display("FAIL thr_int got %b required 1", intOut); end
    endtask

    task automatic test_timeout();
`ifdef USB_HOST_TQ_TIMEOUT_EN
        logic [7:0] d;
        bit seen;
        int cnt = 0;
        do_reset();
        push_desc(2'd1, 1'b0, 1'b0, 7'h01, 4'h1);
        set_run(1'b1);
        wait_req(seen);
        while (transReq === 1'b1 && cnt < 100) begin cnt++; @(negedge busClk); end
        checks++; if (cnt != int'(TMO)) begin failures++; $display("FAIL tmo_len got %0d required %0d", cnt, TMO); end
        bus_read(4'd5, d);
        checks++; if (d !== 8'hFF) begin failures++; $display("FAIL tmo_status got %h required FF", d); end
        bus_read(4'd6, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL tmo_pid got %h required 00", d); end
        bus_read(4'd8, d);
        checks++; if (d !== 8'h13) begin failures++; $display("FAIL tmo_int got %h required 13", d); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] d, e;
        int op;
        do_reset();
        mMask = 5'($urandom_range(1, 15));
        bus_write(4'd9, {3'b0, mMask});
        mMask = mMask & MASK_BITS;
        mThr = 4'($urandom_range(0, 4));
        bus_write(4'd10, {4'b0, mThr});
        set_run(1'b1);
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 4);
            case (op)
                0, 1: push_desc(2'($urandom), 1'($urandom), 1'($urandom), 7'($urandom), 4'($urandom));
                2: if (mDesc.size() != 0) serve(8'($urandom), 4'($urandom), 1'b0, 8'h00);
                3: if (mRes.size() != 0) begin
                    bus_read(4'd5, d);
                    checks++; if (d !== mRes[0].st) begin failures++; $display("FAIL rnd_status got %h required %h", d, mRes[0].st); end
                    bus_read(4'd6, d);
                    e = {1'b0, mRes[0].tag, mRes[0].pid};
                    checks++; if (d !== e) begin failures++; $display("FAIL rnd_pid got %h required %h", d, e); end
                    pop_result();
                end
                default: w1c(8'($urandom_range(0, 31)));
            endcase
            bus_read(4'd4, d);
            checks++; if (d !== exp_qstat()) begin failures++; $display("FAIL rnd_qstat got %h required %h", d, exp_qstat()); end
            bus_read(4'd7, d);
            checks++; if (d !== exp_rstat()) begin failures++; $display("FAIL rnd_rstat got %h required %h", d, exp_rstat()); end
            bus_read(4'd8, d);
            checks++; if (d !== {3'b0, mInt}) begin failures++; $display("FAIL rnd_int got %h required %h", d, {3'b0, mInt}); end
            checks++; if (intOut !== |(mInt & mMask)) begin failures++; $display("FAIL rnd_intout got %b required %b", intOut, |(mInt & mMask)); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_result_full();
        test_flush();
        test_threshold();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
